// File: rtl/bsk_prd_if.sv
// ============================================================================
// Module   : bsk_prd_if
// Brief    : Host strobe/address/select bundle for the BSK PRD block
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface bsk_prd_if;
    logic       iRd;
    logic       iWr;
    logic [1:0] iA;
    logic [3:0] iCS;

    modport master (output iRd, iWr, iA, iCS);
    modport slave  (input  iRd, iWr, iA, iCS);
endinterface

`default_nettype wire

// File: rtl/bsk_prd.sv
// ============================================================================
// Module   : bsk_prd
// Brief    : 16-command BSK PRD readback, LED indication and clk/N test tone
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module bsk_prd #(
    parameter logic [6:0] VERSION  = 7'h25,
    parameter logic [7:0] PASSWORD = 8'hA4,
    parameter logic [3:0] CS_16_01 = 4'b1011,
    parameter logic [3:0] CS_32_17 = 4'b1001,
    parameter int         TEST_DIV = 8
) (
    input  wire             clk,
    input  wire             iRes,
    bsk_prd_if.slave        bus,
    inout  wire  [15:0]     bD,
    input  wire             unit,
    input  wire             iBl,
    input  wire             iDevice,
    input  wire  [15:0]     iCom,
    output logic [15:0]     oComInd,
    output logic            oCS,
    output logic            oTest,
    output logic [15:0]     debug
);

    localparam int c_CNT_W = $clog2(TEST_DIV);

    logic               w_cs;
    logic               w_drive;
    logic               w_rs0;
    logic               w_rs1;
    logic               w_en;
    logic [15:0]        w_rdData;
    logic               w_unused;
    logic [7:0]         r_snap0;
    logic [7:0]         r_snap1;
    logic [15:0]        r_ind;
    logic               r_testEn;
    logic [c_CNT_W-1:0] r_cnt;

    function automatic logic [7:0] enc(input logic [3:0] n);
        return {~n, n};
    endfunction

    assign w_cs    = (bus.iCS == (unit ? CS_32_17 : CS_16_01));
    assign oCS     = ~w_cs;
    assign w_drive = w_cs & ~bus.iRd;

    // Read strobes gated with reset so that releasing reset mid-read re-captures.
    assign w_rs0 = iRes & w_drive & (bus.iA == 2'b00);
    assign w_rs1 = iRes & w_drive & (bus.iA == 2'b01);

    always_ff @(posedge w_rs0 or negedge iRes) begin
        if (!iRes) begin
            r_snap0 <= '0;
        end else begin
            r_snap0 <= iCom[7:0];
        end
    end

    always_ff @(posedge w_rs1 or negedge iRes) begin
        if (!iRes) begin
            r_snap1 <= '0;
        end else begin
            r_snap1 <= iCom[15:8];
        end
    end

    always_ff @(posedge bus.iWr or negedge iRes) begin
        if (!iRes) begin
            r_ind    <= '0;
            r_testEn <= 1'b0;
        end else if (w_cs) begin
            if (bus.iA == 2'b10) begin
                r_ind <= bD;
            end else if (bus.iA == 2'b11) begin
                r_testEn <= bD[0];
            end
        end
    end

    always_comb begin
        w_rdData = '0;
        case (bus.iA)
            2'b00:   w_rdData = {enc(r_snap0[7:4]), enc(r_snap0[3:0])};
            2'b01:   w_rdData = {enc(r_snap1[7:4]), enc(r_snap1[3:0])};
            2'b10:   w_rdData = r_ind;
            default: w_rdData = {PASSWORD, VERSION, r_testEn};
        endcase
    end

    assign bD      = w_drive ? w_rdData : {16{1'bz}};
    assign oComInd = ~r_ind;

    // Reset already clears the counter asynchronously; the sync clear covers iBl/test_en.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            r_cnt <= '0;
        end else if (!(iBl && r_testEn)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign w_en  = iRes & iBl & r_testEn;
    assign oTest = w_en & r_cnt[c_CNT_W-1];

    assign debug    = {12'h000, oTest, r_testEn, w_drive, w_cs};
    assign w_unused = iDevice;

endmodule

`default_nettype wire

// File: tb/tb_bsk_prd.sv
// ============================================================================
// Module   : tb_bsk_prd
// Brief    : Self-checking bench for bsk_prd against a behavioural model
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bsk_prd;

    localparam logic [3:0] C_A = 4'b1011;
    localparam logic [3:0] C_B = 4'b1001;

    logic        clk     = 1'b0;
    logic        iRes    = 1'b1;
    logic        unit    = 1'b0;
    logic        iBl     = 1'b1;
    logic        iDevice = 1'b0;
    logic [15:0] iCom    = 16'h0000;
    logic [15:0] tbData  = 16'h0000;
    logic        tbDrv   = 1'b1;
    wire  [15:0] bD;
    logic [15:0] oComInd;
    logic [15:0] debug;
    logic        oCS;
    logic        oTest;

    bsk_prd_if busIf();

    assign bD = tbDrv ? tbData : 16'hzzzz;

    bsk_prd dut (
        .clk     (clk),
        .iRes    (iRes),
        .bus     (busIf),
        .bD      (bD),
        .unit    (unit),
        .iBl     (iBl),
        .iDevice (iDevice),
        .iCom    (iCom),
        .oComInd (oComInd),
        .oCS     (oCS),
        .oTest   (oTest),
        .debug   (debug)
    );

    always #5 clk = ~clk;

    int   errs   = 0;
    int   checks = 0;
    bit   chkOn  = 1'b0;

    // Behavioural model: snapshots hold the full iCom word seen when a read begins.
    logic [15:0] mS0 = '0, mS1 = '0, mR2 = '0;
    logic        mTestEn = 1'b0;
    int          mRun = 0;
    logic        pRs0 = 1'b0, pRs1 = 1'b0, pWr = 1'b1;

    function automatic logic [7:0] enc(input logic [3:0] n);
        return {~n, n};
    endfunction

    function automatic logic mCs();
        return busIf.iCS == (unit ? C_B : C_A);
    endfunction

    function automatic logic [15:0] expRd(input logic [1:0] a);
        case (a)
            2'd0:    return {enc(mS0[7:4]), enc(mS0[3:0])};
            2'd1:    return {enc(mS1[15:12]), enc(mS1[11:8])};
            2'd2:    return mR2;
            default: return {8'hA4, 7'h25, mTestEn};
        endcase
    endfunction

    function automatic logic expTest();
        return iRes && iBl && mTestEn && (((mRun / 4) % 2) == 1);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic modelStrobe();
        logic rs0, rs1;
        if (!iRes) begin
            mS0 = '0; mS1 = '0; mR2 = '0; mTestEn = 1'b0;
        end
        rs0 = iRes && mCs() && !busIf.iRd && (busIf.iA == 2'd0);
        rs1 = iRes && mCs() && !busIf.iRd && (busIf.iA == 2'd1);
        if (rs0 && !pRs0) mS0 = iCom;
        if (rs1 && !pRs1) mS1 = iCom;
        pRs0 = rs0;
        pRs1 = rs1;
    endtask

    task automatic modelWrite();
        if (!pWr && busIf.iWr && iRes && mCs()) begin
            if (busIf.iA == 2'd2) mR2 = tbData;
            else if (busIf.iA == 2'd3) mTestEn = tbData[0];
        end
        pWr = busIf.iWr;
    endtask

    // Data first, then strobes, then the write strobe, each settled before the next.
    task automatic drive(input logic [15:0] com, input logic [15:0] data, input logic [3:0] csv,
                         input logic u, input logic [1:0] a, input logic rd, input logic wr,
                         input logic res, input logic bl);
        @(posedge clk); #1;
        iCom = com; tbData = data; iBl = bl;
        #1;
        busIf.iCS = csv; busIf.iA = a; busIf.iRd = rd; tbDrv = rd; unit = u; iRes = res;
        modelStrobe();
        #1;
        busIf.iWr = wr;
        modelWrite();
    endtask

    task automatic countTrans(input int cyc, output int n);
        logic p;
        n = 0;
        @(negedge clk);
        p = oTest;
        repeat (cyc) begin
            @(negedge clk);
            if (oTest !== p) n++;
            p = oTest;
        end
    endtask

    always @(posedge clk) begin
        if (iRes && iBl && mTestEn) mRun <= mRun + 1;
        else                        mRun <= 0;
    end

    logic eCs, eOt;
    always @(negedge clk) begin
        if (chkOn) begin
            eCs = mCs();
            eOt = expTest();
            chk("oCS", {15'h0, oCS}, {15'h0, !eCs});
            chk("oComInd", oComInd, ~mR2);
            chk("oTest", {15'h0, oTest}, {15'h0, eOt});
            chk("debug", debug, {12'h000, eOt, mTestEn, eCs && !busIf.iRd, eCs});
            if (eCs && !busIf.iRd) chk("bD_read", bD, expRd(busIf.iA));
            else if (tbDrv)        chk("bD_hostdrive", bD, tbData);
        end
    end

    int n;

    initial begin
        busIf.iRd = 1'b1; busIf.iWr = 1'b1; busIf.iA = 2'd0; busIf.iCS = 4'h0;
        #2 iRes = 1'b0;
        repeat (2) @(posedge clk);
        chkOn = 1'b1;

        // Chip-select decode
        drive(16'h1331, 16'h0, 4'h0, 0, 0, 1, 1, 0, 1); @(negedge clk);
        chk("lit_oComInd_reset", oComInd, 16'hFFFF);
        chk("lit_cs0000", {15'h0, oCS}, 16'h0001);
        drive(16'h1331, 16'h0, 4'hF, 0, 0, 1, 1, 1, 1); @(negedge clk);
        chk("lit_cs1111", {15'h0, oCS}, 16'h0001);
        drive(16'h1331, 16'h0, C_A, 0, 0, 1, 1, 1, 1); @(negedge clk);
        chk("lit_cs1011_u0", {15'h0, oCS}, 16'h0000);
        drive(16'h1331, 16'h0, C_A, 1, 0, 1, 1, 1, 1); @(negedge clk);
        chk("lit_cs1011_u1", {15'h0, oCS}, 16'h0001);
        drive(16'h1331, 16'h0, C_B, 1, 0, 1, 1, 1, 1); @(negedge clk);
        chk("lit_cs1001_u1", {15'h0, oCS}, 16'h0000);

        // Reads and snapshot hold
        drive(16'h1331, 16'h0, C_A, 0, 0, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd00", bD, 16'hC3E1);
        drive(16'h0000, 16'h0, C_A, 0, 0, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd00_hold", bD, 16'hC3E1);
        drive(16'h0000, 16'h0, C_A, 0, 1, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd01_zero", bD, 16'hF0F0);
        drive(16'h1331, 16'h0, C_A, 0, 1, 1, 1, 1, 1);
        drive(16'h1331, 16'h0, C_A, 0, 1, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd01", bD, 16'hE1C3);
        drive(16'h1331, 16'h0, C_A, 0, 2, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd10", bD, 16'h0000);
        drive(16'h1331, 16'h0, C_A, 0, 3, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd11", bD, 16'hA44A);

        // Writes
        drive(16'h1331, 16'h1111, C_A, 0, 2, 1, 0, 1, 1); @(negedge clk);
        chk("lit_ind_wrlow", oComInd, 16'hFFFF);
        drive(16'h1331, 16'h1111, C_A, 0, 2, 1, 1, 1, 1); @(negedge clk);
        chk("lit_ind_wr", oComInd, 16'hEEEE);
        drive(16'h1331, 16'h0001, C_A, 0, 3, 1, 0, 1, 1);
        drive(16'h1331, 16'h0001, C_A, 0, 3, 1, 1, 1, 1);
        drive(16'h1331, 16'h0001, C_A, 0, 3, 0, 1, 1, 1); @(negedge clk);
        chk("lit_rd11_ten", bD, 16'hA44B);
        drive(16'h1331, 16'h9231, C_A, 0, 2, 1, 0, 1, 1);
        drive(16'h1331, 16'h9231, 4'h0, 0, 2, 1, 0, 1, 1);
        drive(16'h1331, 16'h9231, 4'h0, 0, 2, 1, 1, 1, 1); @(negedge clk);
        chk("lit_ind_csdrop", oComInd, 16'hEEEE);

        // Test frequency
        drive(16'h1331, 16'h0, C_A, 0, 0, 1, 1, 1, 0);
        countTrans(12, n);
        chk("lit_trans_blocked", 16'(n), 16'd0);
        drive(16'h1331, 16'h0, C_A, 0, 0, 1, 1, 1, 1);
        countTrans(12, n);
        chk("lit_trans_run", 16'(n), 16'd3);
        chk("lit_otest_end", {15'h0, oTest}, 16'h0001);
        drive(16'h1331, 16'h0, C_A, 0, 0, 1, 1, 1, 0); @(negedge clk);
        chk("lit_otest_drop", {15'h0, oTest}, 16'h0000);

        // Reset behaviour and release re-capture
        drive(16'h1111, 16'h0, C_A, 0, 2, 0, 1, 0, 1); @(negedge clk);
        chk("lit_rst_rd10", bD, 16'h0000);
        chk("lit_rst_ind", oComInd, 16'hFFFF);
        drive(16'h1111, 16'h0, C_A, 0, 3, 0, 1, 0, 1); @(negedge clk);
        chk("lit_rst_rd11", bD, 16'hA44A);
        drive(16'h1111, 16'h0, C_A, 0, 0, 0, 1, 0, 1); @(negedge clk);
        chk("lit_rst_rd00", bD, 16'hF0F0);
        drive(16'h1111, 16'h0, C_A, 0, 0, 0, 1, 1, 1); @(negedge clk);
        chk("lit_release_rd00", bD, 16'hE1E1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic u, rd, wr, res, bl;
            logic [3:0] csv;
            u   = ($urandom_range(9) == 0) ? !unit : unit;
            csv = ($urandom_range(9) < 7) ? (u ? C_B : C_A) : 4'($urandom);
            rd  = (busIf.iWr == 1'b0) ? 1'b1 : 1'($urandom);
            wr  = (rd == 1'b0) ? 1'b1 : 1'($urandom);
            res = ($urandom_range(39) != 0);
            bl  = ($urandom_range(9) != 0);
            drive(16'($urandom), 16'($urandom), csv, u, 2'($urandom), rd, wr, res, bl);
        end

        @(negedge clk);
        chkOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bsk_prd.md
Name: bsk_prd

Overview:
- Board-level command/indication interface for a 16-command block (BSK PRD), sitting on an asynchronous host bus with strobes iRd/iWr/iCS/iA and a shared bidirectional data bus.
- Reports 16 command inputs as nibble-coded readback registers.
- Holds a host-written indication register that drives active-low LEDs, a test-enable bit and a fixed version/password word.
- Generates a clk/8 test frequency when enabled.

Parameters:
- VERSION, 7'h25, firmware version reported in register 3 bits [7:1].
- PASSWORD, 8'hA4, constant reported in register 3 bits [15:8].
- CS_16_01, 4'b1011, iCS pattern selecting the unit when unit=0 (commands 1..16).
- CS_32_17, 4'b1001, iCS pattern selecting the unit when unit=1 (commands 17..32).
- TEST_DIV, 8, clk divider for oTest (power of two).

Ports:
- clk  in  1  clock for the test-frequency divider only.
- iRes  in  1  asynchronous active-low reset.
- bD  inout  16  host data bus.
- iRd  in  1  read strobe, active low.
- iWr  in  1  write strobe, active low; data is taken on the rising edge.
- iA  in  2  register address.
- iCS  in  4  chip-select code.
- unit  in  1  unit selector (0 -> CS_16_01, 1 -> CS_32_17).
- iBl  in  1  block, active low (0 = blocked).
- iDevice  in  1  reserved, ignored.
- iCom  in  16  command inputs.
- oComInd  out  16  command indication, active low.
- oCS  out  1  chip selected, active low.
- oTest  out  1  test frequency.
- debug  out  16  debug bus.

Behaviour:
- The single clock is clk; reset is asynchronous and active-low (iRes). All bus-interface registers are strobe-edge-driven; clk drives only the divider.
- Chip select:
  - cs = (iCS == (unit ? CS_32_17 : CS_16_01)); oCS = ~cs, combinational.
  - unit = X/Z gives oCS = X (not required otherwise).
- Bus drive: bD is driven only while cs && !iRd, otherwise high-Z. iRes does not gate driving.
- Nibble code: enc(n) = {~n, n} (8 bits).
- Read map:
  - 00 = {enc(S0[7:4]), enc(S0[3:0])}.
  - 01 = {enc(S1[15:12]), enc(S1[11:8])}.
  - 10 = R2.
  - 11 = {PASSWORD, VERSION, test_en}, i.e. 16'hA44A or 16'hA44B.
- Snapshots:
  - S0 captures iCom on the rising edge of rs0 = iRes && cs && !iRd && iA==00.
  - S1 captures iCom on the rising edge of rs1 (same, iA==01).
  - Snapshots hold while the strobe stays active; a change of iCom mid-read does not alter the data.
  - An address change, iRd toggle, cs toggle or reset release re-arms capture.
  - Reset clears S0/S1 to 0, so the readback is F0F0.
- Writes: on the rising edge of iWr with cs && iRes at that instant:
  - 10 -> R2 = bD.
  - 11 -> test_en = bD[0].
  - Writes to 00/01 are ignored; writes with cs inactive at the edge are ignored.
- Reset clears R2 = 0 and test_en = 0.
- oComInd = ~R2, combinational. Reset value is 16'hFFFF. It is unaffected by cs, iBl and iRd.
- Divider:
  - en = iRes && iBl && test_en.
  - A 3-bit counter increments on posedge clk while en and clears synchronously while !en; it is cleared asynchronously on reset.
  - oTest = en && cnt[2]: toggles every 4 clk cycles (period 8 clk) and drops to 0 immediately on disable.
  - Reset value of oTest is 0.
- debug:
  - [0] cs, [1] cs && !iRd, [2] test_en, [3] oTest.
  - [15:4] = 0.

Test Plan:
- CS decode:
  - iCS=0000 or 1111 -> oCS=1.
  - iCS=1011, unit=0 -> 0.
  - unit=1 -> 1; iCS=1001 -> 0.
  - unit=0, iCS=1011 -> 0.
- Read:
  - iRes=1, iCom=1331, iRd=0, cs on: A=00 -> C3E1; A=01 -> E1C3; A=10 -> 0000; A=11 -> A44A.
  - iCom=0 at A=00 stays C3E1; A=01 -> F0F0.
  - iCom=FFFF stays F0F0. iRd pulse high (bus shows tb data) then low -> 0F0F.
  - cs off -> ZZZZ; cs on with iCom=1111 -> E1E1.
  - iRes=0 -> F0F0; release with 1111 -> E1E1. iWr pulse no effect.
- Write:
  - A=10, bD=1111: iWr low -> oComInd FFFF; rising edge -> EEEE, readback 1111.
  - A=11, bD=0001 -> readback A44B.
  - iWr low, cs dropped before the rising edge -> R2 unchanged.
  - iRes=0 -> A10 reads 0000, A11 reads A44A.
- Indication: reset active, write 9231 -> FFFF; after release write -> 6DCE. cs off or iBl toggles -> unchanged; iRes=0 -> FFFF.
- Test frequency:
  - 12 clk cycles with test_en=0, or iBl=0, or iRes=0 -> 0 transitions, oTest=0.
  - test_en=1, iBl=1 -> 3 transitions, ends at 1.
  - iBl=0 -> oTest 0 at once; re-enable -> 3 transitions again.
